// File: rtl/stream_permutation_unit.sv
// Streaming permutation engine: captures one vector of up to N_MAX words, then
// replays it in pass, rotate, modular-stride or transpose order at one word per cycle.
//
// state | meaning
// IDLE  | waiting for a configuration; cfg_ready high
// LOAD  | writing input words into the buffer until n have arrived
// DRAIN | emitting buffer words in permuted order through the output register
module stream_permutation_unit #(
  parameter int N_MAX = 257,
  parameter int WIDTH = 32,
  parameter int IW    = $clog2(N_MAX + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [IW-1:0]    cfg_n,
  input  logic [IW-1:0]    cfg_step,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [IW:0] ONE    = (IW + 1)'(1);
  localparam logic [IW:0] TWO    = (IW + 1)'(2);
  localparam logic [IW:0] THREE  = (IW + 1)'(3);
  localparam logic [IW:0] NMAX_X = (IW + 1)'(N_MAX);

  state_t state, state_nx;

  logic [1:0]       mode;
  logic [IW-1:0]    n_len;
  logic [IW-1:0]    step;
  logic [IW-1:0]    wr_cnt;
  logic [IW-1:0]    rd_cnt;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_nx;
  logic [WIDTH-1:0] mem [N_MAX];

  logic             cfg_fire, cfg_legal;
  logic             in_fire, last_in;
  logic             out_fire, rd_load;
  logic [IW:0]      n_x, s_x;
  logic [IW:0]      modulus, inc, sum, wrapped;

  assign cfg_ready = (state == IDLE);
  assign in_ready  = (state == LOAD);
  assign busy      = (state != IDLE);

  assign cfg_fire = cfg_valid && cfg_ready;
  assign in_fire  = in_valid && in_ready;
  assign last_in  = in_fire && (wr_cnt == n_len - IW'(1));
  assign out_fire = out_valid && out_ready;
  // Refill the output register whenever it is empty or being emptied this cycle.
  assign rd_load  = (state == DRAIN) && (rd_cnt != n_len) && (!out_valid || out_ready);

  always_comb begin
    n_x       = {1'b0, cfg_n};
    s_x       = {1'b0, cfg_step};
    cfg_legal = (n_x >= TWO) && (n_x <= NMAX_X);
    case (cfg_mode)
      2'd1:    cfg_legal = cfg_legal && (s_x + ONE <= n_x);
      2'd2:    cfg_legal = cfg_legal && (s_x != '0) && (s_x + ONE <= n_x);
      2'd3:    cfg_legal = cfg_legal && (n_x >= THREE) && (s_x != '0) && (s_x + TWO <= n_x);
      default: cfg_legal = cfg_legal;
    endcase
  end

  // Incremental index: one add and at most one subtract of the modulus per word.
  always_comb begin
    modulus = (mode == 2'd3) ? ({1'b0, n_len} - ONE) : {1'b0, n_len};
    inc     = mode[1] ? {1'b0, step} : ONE;
    sum     = {1'b0, idx} + inc;
    wrapped = (sum >= modulus) ? (sum - modulus) : sum;
    idx_nx  = wrapped[IW-1:0];
    if ((mode == 2'd3) && (rd_cnt == n_len - IW'(2)))
      idx_nx = n_len - IW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cfg_fire && cfg_legal) state_nx = LOAD;
      LOAD:    if (last_in)               state_nx = DRAIN;
      DRAIN:   if (out_fire && out_last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_fire) mem[wr_cnt] <= in_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode      <= '0;
      n_len     <= '0;
      step      <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      idx       <= '0;
      cfg_err   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      cfg_err <= cfg_fire && !cfg_legal;
      if (cfg_fire && cfg_legal) begin
        mode   <= cfg_mode;
        n_len  <= cfg_n;
        step   <= cfg_step;
        wr_cnt <= '0;
        rd_cnt <= '0;
        idx    <= (cfg_mode == 2'd1) ? cfg_step : '0;
      end
      if (in_fire) wr_cnt <= wr_cnt + IW'(1);
      if (rd_load) begin
        rd_cnt    <= rd_cnt + IW'(1);
        idx       <= idx_nx;
        out_data  <= mem[idx];
        out_last  <= (rd_cnt == n_len - IW'(1));
        out_valid <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_permutation_unit.sv
// Self-checking bench for stream_permutation_unit: directed test-plan vectors plus
// randomized configurations checked against an arithmetic index model.
module tb_stream_permutation_unit;
  localparam int N_MAX = 257;
  localparam int WIDTH = 32;
  localparam int IW    = 9;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_mode = '0;
  logic [IW-1:0]    cfg_n = '0;
  logic [IW-1:0]    cfg_step = '0;
  logic             cfg_err;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;

  always #5 clk = ~clk;

  stream_permutation_unit #(.N_MAX(N_MAX), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_n     (cfg_n),
    .cfg_step  (cfg_step),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [WIDTH-1:0] vin [N_MAX];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_idx(input int mode, input int n, input int s, input int i);
    case (mode)
      0:       return i;
      1:       return (i + s) % n;
      2:       return (i * s) % n;
      default: return (i == n - 1) ? n - 1 : (i * s) % (n - 1);
    endcase
  endfunction

  function automatic bit ref_legal(input int mode, input int n, input int s);
    if (n < 2 || n > N_MAX) return 1'b0;
    case (mode)
      1:       return s <= n - 1;
      2:       return s >= 1 && s <= n - 1;
      3:       return n >= 3 && s >= 1 && s <= n - 2;
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_vector(input int mode, input int n, input int s,
                            input int rdy_pct, input int gap_pct, input int abort_after);
    logic [WIDTH-1:0] exp_q [$];
    int k, j, c, budget;
    bit fire, stalled;
    logic [WIDTH-1:0] held_d;
    logic held_l;
    for (int i = 0; i < n; i++) exp_q.push_back(vin[ref_idx(mode, n, s, i)]);

    @(negedge clk);
    chk("cfg_ready_idle", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_mode  = mode[1:0];
    cfg_n     = IW'(n);
    cfg_step  = IW'(s);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("busy_load", busy, 1);

    k = 0;
    budget = 0;
    while (k < n && budget < 20 * n + 50) begin
      chk("in_ready_load", in_ready, 1);
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = vin[k];
      fire = in_valid && in_ready;
      @(posedge clk);
      if (fire) k++;
      @(negedge clk);
      budget++;
    end
    in_valid = 1'b0;
    if (k < n) chk("load_timeout", k, n);

    j = 0;
    c = 0;
    stalled = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    while (j < n && c < 20 * n + 50) begin
      if (c == 0) chk("out_valid_first_drain_cycle", out_valid, 0);
      if (c == 1) chk("out_valid_before_edge_e2", out_valid, 1);
      chk("in_ready_drain", in_ready, 0);
      chk("busy_drain", busy, 1);
      if (stalled) begin
        chk("stall_data", out_data, held_d);
        chk("stall_last", out_last, held_l);
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      fire    = out_valid && out_ready;
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_l  = out_last;
      if (fire) begin
        chk("out_data", out_data, exp_q[j]);
        chk("out_last", out_last, j == n - 1);
        j++;
      end
      @(posedge clk);
      if (abort_after > 0 && fire && j == abort_after) begin
        #2 resetn = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        return;
      end
      @(negedge clk);
      c++;
    end
    out_ready = 1'b0;
    if (j < n) chk("drain_timeout", j, n);
    chk("cfg_ready_after", cfg_ready, 1);
    chk("busy_after", busy, 0);
    chk("out_valid_after", out_valid, 0);
  endtask

  task automatic illegal_cfg(input int mode, input int n, input int s);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_mode  = mode[1:0];
    cfg_n     = IW'(n);
    cfg_step  = IW'(s);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("cfg_err_pulse", cfg_err, 1);
    chk("illegal_busy", busy, 0);
    chk("illegal_in_ready", in_ready, 0);
    chk("illegal_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    chk("cfg_err_clear", cfg_err, 0);
    chk("illegal_busy_after", busy, 0);
    chk("illegal_in_ready_after", in_ready, 0);
  endtask

  initial begin
    int mode, n, s;
    #12;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < N_MAX; i++) vin[i] = WIDTH'(i);
    run_vector(1, 257, 1, 100, 0, 0);

    for (int i = 0; i < 7; i++) vin[i] = WIDTH'(10 + i);
    run_vector(2, 7, 3, 100, 0, 0);

    for (int i = 0; i < 12; i++) vin[i] = WIDTH'(i);
    run_vector(3, 12, 4, 100, 0, 0);

    run_vector(0, 5, 0, 30, 0, 0);

    illegal_cfg(0, 258, 0);
    illegal_cfg(3, 12, 11);
    for (int i = 0; i < 7; i++) vin[i] = WIDTH'(10 + i);
    run_vector(2, 7, 3, 100, 0, 0);

    for (int i = 0; i < 8; i++) vin[i] = WIDTH'(100 + i);
    run_vector(0, 8, 0, 100, 0, 3);
    for (int i = 0; i < 4; i++) vin[i] = WIDTH'(50 + i);
    run_vector(0, 4, 0, 100, 0, 0);

    repeat (40) begin
      mode = int'($urandom_range(3));
      n    = int'($urandom_range(26));
      s    = int'($urandom_range(n + 1));
      for (int i = 0; i < N_MAX; i++) vin[i] = $urandom;
      if (ref_legal(mode, n, s))
        run_vector(mode, n, s, int'($urandom_range(100, 40)), int'($urandom_range(30)), 0);
      else
        illegal_cfg(mode, n, s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
